// File: rtl/dvs_ts_surface_mem_if.sv
// dvs_ts_surface_mem_if: request/response bundle between the activation builder and the timestamp surface
interface dvs_ts_surface_mem_if #(
  parameter int WORD_SIZE       = 18,
  parameter int CAVIAR_X_Y_BITS = 9
);
  logic                       cen;
  logic                       rw;
  logic [CAVIAR_X_Y_BITS-1:0] addr_port1_x;
  logic [CAVIAR_X_Y_BITS-1:0] addr_port1_y;
  logic [CAVIAR_X_Y_BITS-1:0] addr_port2_x;
  logic [CAVIAR_X_Y_BITS-1:0] addr_port2_y;
  logic [WORD_SIZE-1:0]       write_data_mem;
  logic                       clr_start;
  logic [WORD_SIZE-1:0]       read_data1_mem;
  logic [WORD_SIZE-1:0]       read_data2_mem;
  logic                       read_data_mem_vld1;
  logic                       read_data_mem_vld2;
  logic                       busy;
  logic                       addr_err;
  modport master (
    output cen, rw, addr_port1_x, addr_port1_y, addr_port2_x, addr_port2_y, write_data_mem, clr_start,
    input  read_data1_mem, read_data2_mem, read_data_mem_vld1, read_data_mem_vld2, busy, addr_err
  );
  modport slave (
    input  cen, rw, addr_port1_x, addr_port1_y, addr_port2_x, addr_port2_y, write_data_mem, clr_start,
    output read_data1_mem, read_data2_mem, read_data_mem_vld1, read_data_mem_vld2, busy, addr_err
  );
endinterface

// File: rtl/dvs_ts_surface_mem.sv
// dvs_ts_surface_mem: per-pixel timestamp surface with two registered read ports, one write port and a clearing sweep
module dvs_ts_surface_mem #(
  parameter int DVS_WIDTH       = 346,
  parameter int DVS_HEIGHT      = 260,
  parameter int WORD_SIZE       = 18,
  parameter int CAVIAR_X_Y_BITS = 9
) (
  input logic clk,
  input logic rst,
  dvs_ts_surface_mem_if.slave bus
);
  localparam int DEPTH = DVS_WIDTH * DVS_HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t               state, state_nxt;
  logic [AW-1:0]        cnt, idx1, idx2, waddr;
  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [WORD_SIZE-1:0] wdata;
  logic                 last, acc, in1, in2, we;
  // The sweep walks the linear index y*DVS_WIDTH+x, which is x fastest then y.
  assign last  = cnt == AW'(DEPTH - 1);
  assign acc   = state == IDLE && bus.cen;
  assign in1   = 32'(bus.addr_port1_x) < DVS_WIDTH && 32'(bus.addr_port1_y) < DVS_HEIGHT;
  assign in2   = 32'(bus.addr_port2_x) < DVS_WIDTH && 32'(bus.addr_port2_y) < DVS_HEIGHT;
  assign idx1  = AW'(bus.addr_port1_y) * AW'(DVS_WIDTH) + AW'(bus.addr_port1_x);
  assign idx2  = AW'(bus.addr_port2_y) * AW'(DVS_WIDTH) + AW'(bus.addr_port2_x);
  assign we    = state == CLEAR || (acc && bus.rw && in1);
  assign waddr = state == CLEAR ? cnt : idx1;
  assign wdata = state == CLEAR ? '0 : bus.write_data_mem;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= CLEAR;
    else state <= state_nxt;
  always_comb state_nxt = state == CLEAR ? (last ? IDLE : CLEAR) : (bus.clr_start ? CLEAR : IDLE);
  always_comb bus.busy = state == CLEAR;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (state == CLEAR && !last) ? cnt + AW'(1) : '0;
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.read_data1_mem     <= '0;
      bus.read_data2_mem     <= '0;
      bus.read_data_mem_vld1 <= 1'b0;
      bus.read_data_mem_vld2 <= 1'b0;
      bus.addr_err           <= 1'b0;
    end else begin
      bus.read_data_mem_vld1 <= acc && !bus.rw;
      bus.read_data_mem_vld2 <= acc && !bus.rw;
      bus.addr_err           <= acc && (bus.rw ? !in1 : !(in1 && in2));
      if (acc && !bus.rw) begin
        bus.read_data1_mem <= in1 ? mem[idx1] : '0;
        bus.read_data2_mem <= in2 ? mem[idx2] : '0;
      end
    end
endmodule
